// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: bubble encoding, sequencing
// states, writeback/operand select encodings and pipeline control bundles.
package pipe_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] BUBBLE = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_FLUSH  = 2'd3
  } ctrl_state_e;

  localparam logic [2:0] WB_X   = 3'd0;
  localparam logic [2:0] WB_ALU = 3'd1;
  localparam logic [2:0] WB_MEM = 3'd2;
  localparam logic [2:0] WB_PC  = 3'd3;
  localparam logic [2:0] WB_CSR = 3'd4;

  localparam logic [1:0] RS1_X   = 2'd0;
  localparam logic [1:0] RS1_RS1 = 2'd1;
  localparam logic [1:0] RS1_PC  = 2'd2;
  localparam logic [1:0] RS1_IMZ = 2'd3;

  localparam logic [2:0] RS2_X   = 3'd0;
  localparam logic [2:0] RS2_RS2 = 3'd1;
  localparam logic [2:0] RS2_IMI = 3'd2;
  localparam logic [2:0] RS2_IMS = 3'd3;
  localparam logic [2:0] RS2_IMJ = 3'd4;
  localparam logic [2:0] RS2_IMU = 3'd5;

  // Two bits per register: at most EXE, MEM and WB can hold a pending write.
  localparam logic [1:0] SB_MAX = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_exe_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Decoder helpers producing the *_used hazard inputs.
  function automatic logic rs1_used(input logic [1:0] sel);
    return sel == RS1_RS1;
  endfunction

  function automatic logic rs2_used(input logic [2:0] sel);
    return sel == RS2_RS2;
  endfunction

  function automatic logic writes_rf(input logic [2:0] wb_sel);
    return wb_sel != WB_X;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register in-flight write counters with issue/retire update and busy
// lookup for the two ID source operands.
module scoreboard
  import pipe_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  logic [REG_AW-1:0] i_issue_rd,
  input  logic              i_retire,
  input  logic [REG_AW-1:0] i_retire_rd,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy
);

  logic [NUM_REGS-1:0][1:0] r_cnt;
  logic [NUM_REGS-1:0][1:0] w_cnt_next;
  logic [1:0]               w_rs1_cnt;
  logic [1:0]               w_rs2_cnt;
  logic                     w_rs1_wb_hit;
  logic                     w_rs2_wb_hit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    if (gi == 0) begin : g_zero
      assign w_cnt_next[gi] = 2'd0;
    end else begin : g_cnt
      logic w_inc;
      logic w_dec;

      assign w_inc = i_issue & (i_issue_rd == REG_AW'(gi));
      assign w_dec = i_retire & (i_retire_rd == REG_AW'(gi));

      // Simultaneous issue and retire cancel; a stray retire at zero holds.
      assign w_cnt_next[gi] =
          (w_inc && !w_dec && r_cnt[gi] != SB_MAX) ? r_cnt[gi] + 2'd1 :
          (w_dec && !w_inc && r_cnt[gi] != 2'd0)   ? r_cnt[gi] - 2'd1 :
                                                      r_cnt[gi];

      a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
          !(w_dec && !w_inc && r_cnt[gi] == 2'd0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign w_rs1_cnt    = r_cnt[i_rs1_addr];
  assign w_rs2_cnt    = r_cnt[i_rs2_addr];
  assign w_rs1_wb_hit = RF_BYPASS && (w_rs1_cnt == 2'd1) && i_retire && (i_retire_rd == i_rs1_addr);
  assign w_rs2_wb_hit = RF_BYPASS && (w_rs2_cnt == 2'd1) && i_retire && (i_retire_rd == i_rs2_addr);

  assign o_rs1_busy = (i_rs1_addr != '0) && (w_rs1_cnt != 2'd0) && !w_rs1_wb_hit;
  assign o_rs2_busy = (i_rs2_addr != '0) && (w_rs2_cnt != 2'd0) && !w_rs2_wb_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall, EXE redirect squash and data
// memory freeze, with a sequencing FSM and saturating stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RF_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rf_wen,
  input  logic              exe_redirect,
  input  logic              mem_access,
  input  logic              dmem_ready,
  input  logic              wb_rf_wen,
  input  logic [REG_AW-1:0] wb_rd_addr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_exe_en,
  output logic              exe_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_exe_bubble,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic             w_freeze;
  logic             w_raw;
  logic             w_rs1_busy;
  logic             w_rs2_busy;
  logic             w_issue;
  logic             w_retire;
  logic             w_stall_evt;
  logic             w_flush_evt;
  pipe_ctrl_t       w_ctrl;
  ctrl_state_e      r_state;
  ctrl_state_e      w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_freeze = mem_access & ~dmem_ready;
  assign w_raw    = id_valid & ((id_rs1_used & w_rs1_busy) | (id_rs2_used & w_rs2_busy));
  assign w_retire = wb_rf_wen & (wb_rd_addr != '0);
  // Only a real instruction actually entering EXE claims its destination.
  assign w_issue  = w_ctrl.id_exe_en & ~w_ctrl.id_exe_bubble & id_valid & id_rf_wen
                  & (id_rd_addr != '0);

  scoreboard #(
    .RF_BYPASS (RF_BYPASS != 0)
  ) u_sb (
    .clk         (clk),
    .rst_n       (reset),
    .i_issue     (w_issue),
    .i_issue_rd  (id_rd_addr),
    .i_retire    (w_retire),
    .i_retire_rd (wb_rd_addr),
    .i_rs1_addr  (id_rs1_addr),
    .i_rs2_addr  (id_rs2_addr),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_RUN;
    if (w_freeze) begin
      w_state_next = ST_FREEZE;
    end else if (exe_redirect) begin
      w_state_next = ST_FLUSH;
    end else if (w_raw) begin
      w_state_next = ST_STALL;
    end
  end

  // A redirect under freeze waits: EXE is frozen, so it is presented again.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (exe_redirect) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_raw) begin
      w_ctrl = CTRL_STALL;
    end
  end

  assign w_stall_evt = w_freeze | (w_raw & ~exe_redirect);
  assign w_flush_evt = exe_redirect & ~w_freeze;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_en         = w_ctrl.pc_en;
  assign if_id_en      = w_ctrl.if_id_en;
  assign id_exe_en     = w_ctrl.id_exe_en;
  assign exe_mem_en    = w_ctrl.exe_mem_en;
  assign mem_wb_en     = w_ctrl.mem_wb_en;
  assign if_id_flush   = w_ctrl.if_id_flush;
  assign id_exe_bubble = w_ctrl.id_exe_bubble;
  assign ctrl_state    = r_state;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: RAW stalls, redirect squash, memory
// freeze, scoreboard depth, x0 handling and reset in the middle of a stall.
module tb_hazard_ctrl;

  localparam logic [6:0] C_RUN = 7'b1111100;
  localparam logic [6:0] C_STL = 7'b0011101;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_FLS = 7'b1111111;
  localparam logic [6:0] C_RST = 7'b0000011;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_rf_wen;
  logic        exe_redirect;
  logic        mem_access;
  logic        dmem_ready;
  logic        wb_rf_wen;
  logic [4:0]  wb_rd_addr;
  logic        pc_en;
  logic        if_id_en;
  logic        id_exe_en;
  logic        exe_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_exe_bubble;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .RF_BYPASS (0),
    .CNT_W     (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_rd_addr    (id_rd_addr),
    .id_rf_wen     (id_rf_wen),
    .exe_redirect  (exe_redirect),
    .mem_access    (mem_access),
    .dmem_ready    (dmem_ready),
    .wb_rf_wen     (wb_rf_wen),
    .wb_rd_addr    (wb_rd_addr),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_exe_en     (id_exe_en),
    .exe_mem_en    (exe_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_exe_bubble (id_exe_bubble),
    .ctrl_state    (ctrl_state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       redir;
    logic       macc;
    logic       rdy;
    logic       wbw;
    logic [4:0] wbrd;
    logic [6:0] ctl;
    int         st;
    int         sc;
    int         fc;
    int         c7;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, int rs1, logic u1, int rs2, logic u2, int rd, logic wen,
                              logic redir, logic macc, logic rdy, logic wbw, int wbrd,
                              logic [6:0] ctl, int st, int sc, int fc, int c7);
    vec_t m;
    m.v = v; m.rs1 = 5'(rs1); m.u1 = u1; m.rs2 = 5'(rs2); m.u2 = u2;
    m.rd = 5'(rd); m.wen = wen; m.redir = redir; m.macc = macc; m.rdy = rdy;
    m.wbw = wbw; m.wbrd = 5'(wbrd); m.ctl = ctl; m.st = st; m.sc = sc; m.fc = fc; m.c7 = c7;
    return m;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_bubble};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1_addr = t.rs1; id_rs1_used = t.u1; id_rs2_addr = t.rs2;
    id_rs2_used = t.u2; id_rd_addr = t.rd; id_rf_wen = t.wen; exe_redirect = t.redir;
    mem_access = t.macc; dmem_ready = t.rdy; wb_rf_wen = t.wbw; wb_rd_addr = t.wbrd;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,0,0,0);

    // RAW: add x1 then add x2,x1,x1 (producer retires at vector 3)
    tbl.push_back(mk(1,0,1,0,1,1,1, 0,0,1,0,0, C_RUN,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,1,2,1, 0,0,1,0,0, C_STL,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,1,2,1, 0,0,1,0,0, C_STL,1,1,0,0));
    tbl.push_back(mk(1,1,1,1,1,2,1, 0,0,1,1,1, C_STL,1,2,0,0));
    tbl.push_back(mk(1,1,1,1,1,2,1, 0,0,1,0,0, C_RUN,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,1,2, C_RUN,0,3,0,0));
    // redirect while ID holds a dependent of x5
    tbl.push_back(mk(1,0,1,0,0,5,1, 0,0,1,0,0, C_RUN,0,3,0,0));
    tbl.push_back(mk(1,0,1,0,1,0,0, 0,0,1,0,0, C_RUN,0,3,0,0));
    tbl.push_back(mk(1,5,1,0,0,6,1, 1,0,1,0,0, C_FLS,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,1,5, C_RUN,3,3,1,0));
    // four-cycle freeze, redirect raised during it and applied afterwards
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0, C_FRZ,0,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0,0, C_FRZ,2,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,0,0,0, C_FRZ,2,5,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,0,0,0, C_FRZ,2,6,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,1,0,0, C_FLS,2,7,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,3,7,2,0));
    // three writers to x7, then a reader that also writes x7
    tbl.push_back(mk(1,0,0,0,0,7,1, 0,0,1,0,0, C_RUN,0,7,2,0));
    tbl.push_back(mk(1,0,0,0,0,7,1, 0,0,1,0,0, C_RUN,0,7,2,1));
    tbl.push_back(mk(1,0,0,0,0,7,1, 0,0,1,0,0, C_RUN,0,7,2,2));
    tbl.push_back(mk(1,7,1,0,0,7,1, 0,0,1,1,7, C_STL,0,7,2,3));
    tbl.push_back(mk(1,7,1,0,0,7,1, 0,0,1,1,7, C_STL,1,8,2,2));
    tbl.push_back(mk(1,7,1,0,0,7,1, 0,0,1,1,7, C_STL,1,9,2,1));
    tbl.push_back(mk(1,7,1,0,0,7,1, 0,0,1,0,0, C_RUN,1,10,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,10,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,10,2,1));
    // same-cycle issue and retire to x7
    tbl.push_back(mk(1,0,0,0,0,7,1, 0,0,1,1,7, C_RUN,0,10,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,10,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0, C_RUN,0,10,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,1,7, C_RUN,0,10,2,1));
    // x0 as source, destination and retire target
    tbl.push_back(mk(1,0,1,0,1,0,1, 0,0,1,1,0, C_RUN,0,10,2,0));
    tbl.push_back(mk(1,0,1,0,1,0,1, 0,0,1,1,0, C_RUN,0,10,2,0));

    reset = 1'b1;
    drive(idle);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", int'(ctl_now()), int'(C_RST));
    chk("reset_state", int'(ctrl_state), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_flush_cnt", int'(flush_cnt), 0);
    $display("reset ctl=%b state=%0d", ctl_now(), ctrl_state);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_ctl", i), int'(ctl_now()), int'(tbl[i].ctl));
      chk($sformatf("v%0d_state", i), int'(ctrl_state), tbl[i].st);
      chk($sformatf("v%0d_stall_cnt", i), int'(stall_cnt), tbl[i].sc);
      chk($sformatf("v%0d_flush_cnt", i), int'(flush_cnt), tbl[i].fc);
      chk($sformatf("v%0d_cnt7", i), int'(dut.u_sb.r_cnt[7]), tbl[i].c7);
      $display("vec %0d ctl=%b state=%0d stall=%0d flush=%0d cnt7=%0d",
               i, ctl_now(), ctrl_state, stall_cnt, flush_cnt, dut.u_sb.r_cnt[7]);
    end

    @(negedge clk);
    drive(idle);
    #1;
    chk("cnt0_zero", int'(dut.u_sb.r_cnt[0]), 0);
    chk("cnt1_zero", int'(dut.u_sb.r_cnt[1]), 0);
    chk("cnt5_zero", int'(dut.u_sb.r_cnt[5]), 0);
    chk("cnt7_zero", int'(dut.u_sb.r_cnt[7]), 0);
    $display("scoreboard drained cnt1=%0d cnt7=%0d", dut.u_sb.r_cnt[1], dut.u_sb.r_cnt[7]);

    // reset asserted in the middle of a RAW stall on x3
    @(negedge clk);
    drive(mk(1,0,0,0,0,3,1, 0,0,1,0,0, C_RUN,0,0,0,0));
    #1;
    chk("x3_writer_ctl", int'(ctl_now()), int'(C_RUN));
    @(negedge clk);
    drive(mk(1,3,1,0,0,4,1, 0,0,1,0,0, C_STL,0,0,0,0));
    #1;
    chk("x3_reader_ctl", int'(ctl_now()), int'(C_STL));
    @(posedge clk);
    #1;
    chk("pre_reset_state", int'(ctrl_state), 1);
    chk("pre_reset_stall_cnt", int'(stall_cnt), 11);
    chk("pre_reset_cnt3", int'(dut.u_sb.r_cnt[3]), 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_ctl", int'(ctl_now()), int'(C_RST));
    chk("mid_reset_state", int'(ctrl_state), 0);
    chk("mid_reset_stall_cnt", int'(stall_cnt), 0);
    chk("mid_reset_flush_cnt", int'(flush_cnt), 0);
    chk("mid_reset_cnt3", int'(dut.u_sb.r_cnt[3]), 0);
    $display("mid-stall reset ctl=%b state=%0d stall=%0d", ctl_now(), ctrl_state, stall_cnt);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_reset_ctl", int'(ctl_now()), int'(C_RUN));
    @(posedge clk);
    #1;
    chk("post_reset_cnt4", int'(dut.u_sb.r_cnt[4]), 1);
    chk("post_reset_stall_cnt", int'(stall_cnt), 0);
    $display("post-reset issue ctl=%b cnt4=%0d", ctl_now(), dut.u_sb.r_cnt[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
